// File: rtl/pipeline_ctrl_pkg.sv
// Shared decode table, state encoding and sizing for the pipeline hazard controller.
package pipeline_ctrl_pkg;

  localparam int REG_W           = 4;
  localparam int NUM_REGS        = 16;
  localparam int BR_FLUSH_CYCLES = 2;
  localparam int MAX_STALL       = 15;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_LW   = 4'h3;
  localparam logic [3:0] OP_SW   = 4'h4;
  localparam logic [3:0] OP_BEQ  = 4'h5;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  function automatic logic uses_rs(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_ADDI) || (op == OP_LW) ||
           (op == OP_SW)  || (op == OP_BEQ);
  endfunction

  function automatic logic uses_rt(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

  function automatic logic writes_rd(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_ADDI) || (op == OP_LW);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Busy bit per register for writes in flight; flags a RAW hazard for the ID instruction.
// A same-cycle writeback bypasses the hazard, and a set beats a clear on the same register.
module hazard_scoreboard
  import pipeline_ctrl_pkg::*;
#(
  parameter int P_REG_W    = REG_W,
  parameter int P_NUM_REGS = NUM_REGS
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_id_valid,
  input  logic               i_uses_rs,
  input  logic               i_uses_rt,
  input  logic [P_REG_W-1:0] i_rs,
  input  logic [P_REG_W-1:0] i_rt,
  input  logic               i_set_en,
  input  logic [P_REG_W-1:0] i_set_rd,
  input  logic               i_wb_valid,
  input  logic [P_REG_W-1:0] i_wb_rd,
  output logic               o_hazard
);

  logic [P_NUM_REGS-1:0] r_busy;
  logic [P_NUM_REGS-1:0] w_busy_next;
  logic                  w_rs_hit;
  logic                  w_rt_hit;

  always_ff @(posedge clock) begin
    if (reset) r_busy <= '0;
    else       r_busy <= w_busy_next;
  end

  always_comb begin
    w_busy_next = r_busy;
    if (i_wb_valid) w_busy_next[i_wb_rd] = 1'b0;
    if (i_set_en && (i_set_rd != '0)) w_busy_next[i_set_rd] = 1'b1;
    w_busy_next[0] = 1'b0;
  end

  always_comb begin
    w_rs_hit = i_uses_rs && r_busy[i_rs] && !(i_wb_valid && (i_wb_rd == i_rs));
    w_rt_hit = i_uses_rt && r_busy[i_rt] && !(i_wb_valid && (i_wb_rd == i_rt));
    o_hazard = i_id_valid && (w_rs_hit || w_rt_hit);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: RAW stalls, branch flush sequencing.
// Outputs are combinational from state and inputs, so a stall or flush acts in the same cycle.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int P_REG_W           = REG_W,
  parameter int P_NUM_REGS        = NUM_REGS,
  parameter int P_BR_FLUSH_CYCLES = BR_FLUSH_CYCLES,
  parameter int P_MAX_STALL       = MAX_STALL
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_id_valid,
  input  logic [3:0]         i_id_opcode,
  input  logic [P_REG_W-1:0] i_id_rd,
  input  logic [P_REG_W-1:0] i_id_rs,
  input  logic [P_REG_W-1:0] i_id_rt,
  input  logic               i_wb_valid,
  input  logic [P_REG_W-1:0] i_wb_rd,
  input  logic               i_br_resolve,
  input  logic               i_br_taken,
  output logic               o_pc_write_en,
  output logic               o_if_id_write_en,
  output logic               o_if_id_flush,
  output logic               o_id_ex_bubble,
  output logic [7:0]         o_stall_count,
  output logic               o_hazard_timeout
);

  localparam int CNT_W = $clog2(P_BR_FLUSH_CYCLES + 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] w_flush_cnt_next;
  logic [7:0]       r_stall_cnt;
  logic [7:0]       w_stall_cnt_next;
  logic             r_timeout;
  logic             w_hazard;
  logic             w_branch;
  logic             w_issue;

  assign w_branch = i_br_resolve && i_br_taken;
  // A flushed or branch-killed instruction never issues, so it must not mark its rd busy.
  assign w_issue  = i_id_valid && !w_hazard && (r_state != ST_FLUSH) && !w_branch;

  hazard_scoreboard #(
    .P_REG_W    (P_REG_W),
    .P_NUM_REGS (P_NUM_REGS)
  ) u_scoreboard (
    .clock      (clock),
    .reset      (reset),
    .i_id_valid (i_id_valid),
    .i_uses_rs  (uses_rs(i_id_opcode)),
    .i_uses_rt  (uses_rt(i_id_opcode)),
    .i_rs       (i_id_rs),
    .i_rt       (i_id_rt),
    .i_set_en   (w_issue && writes_rd(i_id_opcode)),
    .i_set_rd   (i_id_rd),
    .i_wb_valid (i_wb_valid),
    .i_wb_rd    (i_wb_rd),
    .o_hazard   (w_hazard)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= '0;
      r_stall_cnt <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_flush_cnt <= w_flush_cnt_next;
      r_stall_cnt <= w_stall_cnt_next;
      r_timeout   <= r_timeout || (w_stall_cnt_next == 8'(P_MAX_STALL));
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_flush_cnt_next = r_flush_cnt;
    w_stall_cnt_next = r_stall_cnt;
    if (w_branch) begin
      w_stall_cnt_next = '0;
      if (P_BR_FLUSH_CYCLES > 1) begin
        w_state_next     = ST_FLUSH;
        w_flush_cnt_next = CNT_W'(P_BR_FLUSH_CYCLES - 1);
      end else begin
        w_state_next     = ST_RUN;
      end
    end else if (r_state == ST_FLUSH) begin
      w_stall_cnt_next = '0;
      w_flush_cnt_next = r_flush_cnt - 1'b1;
      if (r_flush_cnt <= CNT_W'(1)) w_state_next = ST_RUN;
    end else if (w_hazard) begin
      w_state_next     = ST_STALL;
      w_stall_cnt_next = (r_stall_cnt == 8'hFF) ? r_stall_cnt : r_stall_cnt + 8'd1;
    end else begin
      w_state_next     = ST_RUN;
      w_stall_cnt_next = '0;
    end
  end

  always_comb begin
    o_pc_write_en    = 1'b1;
    o_if_id_write_en = 1'b1;
    o_if_id_flush    = 1'b0;
    o_id_ex_bubble   = 1'b0;
    if (!reset) begin
      if (w_branch || (r_state == ST_FLUSH)) begin
        o_if_id_flush  = 1'b1;
        o_id_ex_bubble = 1'b1;
      end else if (w_hazard) begin
        o_pc_write_en    = 1'b0;
        o_if_id_write_en = 1'b0;
        o_id_ex_bubble   = 1'b1;
      end
    end
  end

  assign o_stall_count    = r_stall_cnt;
  assign o_hazard_timeout = r_timeout;

endmodule
